// File: rtl/acc_cpu_param.sv
// rtl/acc_cpu_param.sv - parametrised single-cycle accumulator processor core
// Executes one instruction per clock from a combinational program memory.
module acc_cpu_param #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int NREG   = 16,
  parameter int SDEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          run,
  input  logic          resume,
  output logic [AW-1:0] imem_addr,
  input  logic [AW+3:0] imem_data,
  output logic [DW-1:0] acc,
  output logic [DW-1:0] ext,
  output logic          flag_c,
  output logic          flag_z,
  output logic          halted,
  output logic          fault
);

  localparam int RAW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SPW = $clog2(SDEPTH + 1);
  localparam int SIW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   pc, pc_nxt, pc_inc;
  logic [DW-1:0]   acc_r, acc_nxt, ext_r, ext_nxt;
  logic            c_r, c_nxt, z_r, z_nxt;
  logic [DW-1:0]   regs [NREG];
  logic [AW-1:0]   stack [SDEPTH];
  logic [SPW-1:0]  sp, sp_nxt;
  logic [SIW-1:0]  sidx_push, sidx_top;
  logic            reg_we, push, acc_wr;
  logic [3:0]      opcode;
  logic [AW-1:0]   operand;
  logic [RAW-1:0]  ridx;
  logic [DW-1:0]   rval;
  logic [2*DW-1:0] prod;
  logic [DW:0]     sum;

  assign opcode    = imem_data[AW+3:AW];
  assign operand   = imem_data[AW-1:0];
  assign ridx      = operand[RAW-1:0];
  assign rval      = regs[ridx];
  assign pc_inc    = pc + 1'b1;
  assign sum       = {1'b0, acc_r} + {1'b0, rval};
  assign prod      = {{DW{1'b0}}, acc_r} * {{DW{1'b0}}, rval};
  assign sidx_push = SIW'(sp);
  assign sidx_top  = SIW'(sp - 1'b1);

  assign imem_addr = pc;
  assign acc       = acc_r;
  assign ext       = ext_r;
  assign flag_c    = c_r;
  assign flag_z    = z_r;
  assign halted    = (state == S_HALT);
  assign fault     = (state == S_FAULT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    acc_nxt   = acc_r;
    ext_nxt   = ext_r;
    c_nxt     = c_r;
    z_nxt     = z_r;
    sp_nxt    = sp;
    reg_we    = 1'b0;
    push      = 1'b0;
    acc_wr    = 1'b0;
    if (run) begin
      case (state)
        S_RUN: begin
          pc_nxt = pc_inc;
          acc_wr = 1'b1;
          case (opcode)
            4'h0: acc_wr = 1'b0;
            4'h1: begin acc_nxt = sum[DW-1:0]; c_nxt = sum[DW]; end
            4'h2: begin acc_nxt = acc_r - rval; c_nxt = (acc_r < rval); end
            4'h3: begin {ext_nxt, acc_nxt} = prod; c_nxt = 1'b0; end
            4'h4: acc_nxt = acc_r & rval;
            4'h5: acc_nxt = acc_r | rval;
            4'h6: acc_nxt = acc_r ^ rval;
            4'h7: acc_nxt = DW'(operand);
            4'h8: begin acc_wr = 1'b0; if (c_r) pc_nxt = operand; end
            4'h9: acc_nxt = rval;
            4'hA: begin acc_wr = 1'b0; reg_we = 1'b1; end
            4'hB: begin
              acc_wr = 1'b0;
              if (sp == SP_FULL) begin
                state_nxt = S_FAULT;
                pc_nxt    = pc;
              end else begin
                push   = 1'b1;
                sp_nxt = sp + 1'b1;
                pc_nxt = operand;
              end
            end
            4'hC: begin
              acc_wr = 1'b0;
              if (~|sp) begin
                state_nxt = S_FAULT;
                pc_nxt    = pc;
              end else begin
                sp_nxt = sp - 1'b1;
                pc_nxt = stack[sidx_top];
              end
            end
            4'hD: begin acc_wr = 1'b0; if (z_r) pc_nxt = operand; end
            4'hE: acc_nxt = ext_r;
            default: begin
              acc_wr    = 1'b0;
              state_nxt = S_HALT;
              pc_nxt    = pc;
            end
          endcase
          if (acc_wr) z_nxt = ~|acc_nxt;
        end
        S_HALT: begin
          // Resume skips past the HLT that stopped us.
          if (resume) begin
            state_nxt = S_RUN;
            pc_nxt    = pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_RUN;
      pc    <= '0;
      acc_r <= '0;
      ext_r <= '0;
      c_r   <= 1'b0;
      z_r   <= 1'b0;
      sp    <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      for (int i = 0; i < SDEPTH; i++) stack[i] <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      acc_r <= acc_nxt;
      ext_r <= ext_nxt;
      c_r   <= c_nxt;
      z_r   <= z_nxt;
      sp    <= sp_nxt;
      if (reg_we) regs[ridx] <= acc_r;
      if (push) stack[sidx_push] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
// tb/tb_acc_cpu_param.sv - directed bench for acc_cpu_param with an ISA-level reference model
// The model steps the architectural state each clock; directed checks pin hand-computed values.
module tb_acc_cpu_param;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       run = 1'b1;
  logic       resume = 1'b0;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] acc, ext;
  logic       flag_c, flag_z, halted, fault;
  logic [7:0] prog [16];

  int nvec = 0;
  int nerr = 0;

  // ISA-level reference state
  int m_pc, m_acc, m_ext, m_c, m_z, m_state;
  int m_regs [16];
  int m_stack [$];

  acc_cpu_param #(.DW(8), .AW(4), .NREG(16), .SDEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .run(run), .resume(resume),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .acc(acc), .ext(ext), .flag_c(flag_c), .flag_z(flag_z),
    .halted(halted), .fault(fault)
  );

  assign imem_data = prog[imem_addr];

  always #5 clk = ~clk;

  function automatic logic [7:0] ins(input logic [3:0] op, input logic [3:0] opd);
    return {op, opd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_ext = 0; m_c = 0; m_z = 0; m_state = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_stack.delete();
  endtask

  task automatic model_step();
    logic [7:0] w;
    int op, opd, r, t, nxt;
    w = prog[m_pc];
    op = int'(w[7:4]);
    opd = int'(w[3:0]);
    r = m_regs[opd];
    if (!run || m_state == 2) return;
    if (m_state == 1) begin
      if (resume) begin
        m_state = 0;
        m_pc = (m_pc + 1) % 16;
      end
      return;
    end
    nxt = (m_pc + 1) % 16;
    case (op)
      1: begin t = m_acc + r; m_c = (t > 255) ? 1 : 0; m_acc = t % 256; end
      2: begin m_c = (m_acc < r) ? 1 : 0; m_acc = (m_acc - r + 256) % 256; end
      3: begin t = m_acc * r; m_ext = t / 256; m_acc = t % 256; m_c = 0; end
      4: m_acc = m_acc & r;
      5: m_acc = m_acc | r;
      6: m_acc = m_acc ^ r;
      7: m_acc = opd;
      8: if (m_c != 0) nxt = opd;
      9: m_acc = r;
      10: m_regs[opd] = m_acc;
      11: if (m_stack.size() == 4) begin m_state = 2; nxt = m_pc; end
          else begin m_stack.push_back(nxt); nxt = opd; end
      12: if (m_stack.size() == 0) begin m_state = 2; nxt = m_pc; end
          else nxt = m_stack.pop_back();
      13: if (m_z != 0) nxt = opd;
      14: m_acc = m_ext;
      15: begin m_state = 1; nxt = m_pc; end
      default: ;
    endcase
    if ((op >= 1 && op <= 7) || op == 9 || op == 14) m_z = (m_acc == 0) ? 1 : 0;
    m_pc = nxt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // Compare every cycle, half a period away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("m.pc", imem_addr, m_pc);
      chk("m.acc", acc, m_acc);
      chk("m.ext", ext, m_ext);
      chk("m.c", flag_c, m_c);
      chk("m.z", flag_z, m_z);
      chk("m.halted", halted, (m_state == 1) ? 1 : 0);
      chk("m.fault", fault, (m_state == 2) ? 1 : 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic begin_prog();
    rstn = 1'b0;
    run = 1'b1;
    resume = 1'b0;
    step(2);
    for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
  endtask

  initial begin
    int exp_pc [15] = '{3, 6, 9, 12, 10, 7, 4, 1, 15, 13, 0, 3, 6, 9, 9};

    // Reset state
    begin_prog();
    chk("rst.pc", imem_addr, 0);
    chk("rst.acc", acc, 0);
    chk("rst.ext", ext, 0);
    chk("rst.c", flag_c, 0);
    chk("rst.z", flag_z, 0);
    chk("rst.halted", halted, 0);
    chk("rst.fault", fault, 0);

    // ADD carry, BRC, MUL high half, BRZ taken/not, MOVX
    prog[0] = ins(7, 8);   prog[1] = ins(10, 5); prog[2] = ins(1, 5);
    prog[3] = ins(10, 5);  prog[4] = ins(1, 5);  prog[5] = ins(10, 2);
    prog[6] = ins(7, 15);  prog[7] = ins(3, 5);  prog[8] = ins(1, 2);
    prog[9] = ins(8, 13);  prog[10] = ins(14, 0); prog[11] = ins(13, 0);
    prog[12] = ins(15, 0); prog[13] = ins(3, 2); prog[14] = ins(13, 10);
    rstn = 1'b1;
    step(9);
    chk("add.acc", acc, 8'h10);
    chk("add.c", flag_c, 1);
    chk("add.z", flag_z, 0);
    chk("add.pc", imem_addr, 9);
    step(1); chk("brc.pc", imem_addr, 13);
    step(1);
    chk("mul.ext", ext, 8'h02);
    chk("mul.acc", acc, 8'h00);
    chk("mul.z", flag_z, 1);
    chk("mul.c", flag_c, 0);
    step(1); chk("brz.pc", imem_addr, 10);
    step(1);
    chk("movx.acc", acc, 8'h02);
    chk("movx.z", flag_z, 0);
    step(1); chk("brz_nt.pc", imem_addr, 12);
    step(1); chk("hlt.halted", halted, 1);
    step(10); chk("hlt.pc", imem_addr, 12);

    // Logic ops, SUB borrow, HALT/resume, run stall, STO->MOV, PC wrap
    begin_prog();
    prog[0] = ins(7, 12); prog[1] = ins(10, 3); prog[2] = ins(7, 10);
    prog[3] = ins(6, 3);  prog[4] = ins(2, 3);  prog[5] = ins(15, 0);
    prog[6] = ins(4, 3);  prog[7] = ins(5, 3);  prog[8] = ins(2, 3);
    prog[9] = ins(7, 5);  prog[10] = ins(10, 7); prog[11] = ins(9, 7);
    for (int i = 12; i < 16; i++) prog[i] = ins(0, 0);
    rstn = 1'b1;
    step(5);
    chk("sub.acc", acc, 8'hFA);
    chk("sub.c", flag_c, 1);
    step(1); chk("hlt5.halted", halted, 1);
    step(10); chk("hlt5.pc", imem_addr, 5);
    run = 1'b0; resume = 1'b1; step(1); resume = 1'b0; run = 1'b1;
    step(2);
    chk("res_norun.halted", halted, 1);
    chk("res_norun.pc", imem_addr, 5);
    resume = 1'b1; step(1); resume = 1'b0;
    chk("resume.pc", imem_addr, 6);
    chk("resume.halted", halted, 0);
    step(1);
    chk("and.acc", acc, 8'h08);
    chk("and.c", flag_c, 1);
    run = 1'b0; step(3); run = 1'b1;
    chk("stall.pc", imem_addr, 7);
    step(2);
    chk("sub0.acc", acc, 8'h00);
    chk("sub0.z", flag_z, 1);
    step(3);
    chk("stomov.acc", acc, 8'h05);
    step(3); chk("wrap.pc15", imem_addr, 15);
    step(1); chk("wrap.pc0", imem_addr, 0);
    step(1); chk("wrap.pc1", imem_addr, 1);

    // Nested CALL/RET, CALL from pc 15 returns to 0, overflow fault
    begin_prog();
    prog[0] = ins(11, 3);  prog[1] = ins(11, 15); prog[3] = ins(11, 6);
    prog[4] = ins(12, 0);  prog[6] = ins(11, 9);  prog[7] = ins(12, 0);
    prog[9] = ins(11, 12); prog[10] = ins(12, 0); prog[12] = ins(12, 0);
    prog[13] = ins(12, 0); prog[15] = ins(11, 13);
    rstn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk($sformatf("call.pc%0d", i), imem_addr, exp_pc[i]);
      if (i == 13) chk("call.nofault", fault, 0);
    end
    chk("ovf.fault", fault, 1);
    step(5);
    chk("ovf.pc", imem_addr, 9);

    // RET on an empty stack; resume has no effect in FAULT
    begin_prog();
    prog[0] = ins(12, 0);
    rstn = 1'b1;
    step(1);
    chk("unf.fault", fault, 1);
    resume = 1'b1; step(1); resume = 1'b0;
    chk("unf.hold", fault, 1);
    chk("unf.pc", imem_addr, 0);

    // Asynchronous reset mid-run clears registers too
    begin_prog();
    prog[0] = ins(7, 1); prog[1] = ins(10, 2); prog[2] = ins(7, 4);
    prog[3] = ins(10, 1); prog[4] = ins(3, 1); prog[5] = ins(1, 2);
    prog[6] = ins(10, 1); prog[7] = ins(7, 5); prog[8] = ins(3, 1);
    prog[9] = ins(10, 4);
    rstn = 1'b1;
    step(10);
    chk("pre_rst.acc", acc, 8'h55);
    rstn = 1'b0;
    #1;
    chk("arst.acc", acc, 0);
    chk("arst.pc", imem_addr, 0);
    chk("arst.c", flag_c, 0);
    chk("arst.z", flag_z, 0);
    step(1);
    prog[0] = ins(9, 4);
    rstn = 1'b1;
    step(1);
    chk("mov_after_rst.acc", acc, 8'h00);
    chk("mov_after_rst.z", flag_z, 1);
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/acc_cpu_param.md
# acc_cpu_param

Parametrised single-cycle accumulator processor core: fetches one instruction per cycle from an external combinational program memory, executes against an internal register file, and holds results in an accumulator plus an extension register. It adds width/depth parameters, carry and zero flags, a hardware call/return stack, halt/resume and a fault state. It is the execution core of the next processor generation, sitting between the program memory and the top-level wrapper.

## Interface
- DW, 8, data width of ACC, EXT and registers
- AW, 4, program-counter width; operand field width
- NREG, 16, register count; power of two, NREG <= 2**AW
- SDEPTH, 4, call-stack depth (entries), >= 1
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- run  in  1  execute enable; low stalls all state (PC, ACC, flags, stack, regs)
- resume  in  1  single-cycle pulse; leaves HALT
- imem_addr  out  AW  instruction address, equals pc (combinational)
- imem_data  in  4+AW  instruction: opcode [AW+3:AW], operand [AW-1:0]
- acc  out  DW  accumulator
- ext  out  DW  high half of last MUL
- flag_c, flag_z  out  1  carry/borrow, zero
- halted  out  1  state == HALT
- fault  out  1  state == FAULT

## Operation
- Register address = operand[log2(NREG)-1:0]; upper operand bits ignored for register ops.
- Opcodes: 0000 NOP; 0001 ADD {C,ACC}<=ACC+R; 0010 SUB ACC<=ACC-R, C<=borrow (ACC<R); 0011 MUL {EXT,ACC}<=ACC*R (2*DW-bit product), C<=0; 0100 AND; 0101 OR; 0110 XOR; 0111 LDI ACC<=zero-extended/truncated operand; 1000 BRC: PC<=operand if C; 1001 MOV ACC<=R; 1010 STO R<=ACC; 1011 CALL push PC+1, PC<=operand; 1100 RET PC<=pop; 1101 BRZ PC<=operand if Z; 1110 MOVX ACC<=EXT; 1111 HLT.
- Z updated to (new ACC==0) on every ACC-writing opcode (0001-0111, 1001, 1110); C changed only by ADD/SUB/MUL; logic ops leave C.
- Branch not taken, and all non-control ops: PC<=PC+1, wrapping 2**AW-1 -> 0. CALL return address wraps identically.
- Stack: SDEPTH entries of AW bits, pointer 0..SDEPTH. CALL when full -> FAULT, no push, PC unchanged. RET when empty -> FAULT, PC unchanged.
- States: RUN, HALT, FAULT. RUN --HLT--> HALT (PC stays on HLT). HALT --resume--> RUN with PC<=PC+1. FAULT exits only on reset. In HALT/FAULT nothing updates; resume ignored outside HALT.
- Reset values: pc 0, acc 0, ext 0, flag_c 0, flag_z 0, all registers 0, stack pointer 0, state RUN.

## Timing
- One instruction per clk edge when run=1 and state RUN; results visible the cycle after the edge.
- STO then MOV of the same register on consecutive cycles returns the stored value (write completes at the STO edge).
- run=0 overrides resume: a resume pulse while run=0 is ignored.
- Fault and halted assert the cycle after the offending/HLT edge and hold.
- rstn assertion mid-instruction clears everything asynchronously; first fetch after deassertion is address 0.

## Test plan
- ADD carry (DW=8): LDI 0xF (then STO R1), LDI... set ACC=0xF0, R2=0x20, ADD R2 -> acc 0x10, flag_c 1, flag_z 0; BRC 9 -> pc 9.
- MUL: ACC=0x10, R3=0x20, MUL R3 -> ext 0x02, acc 0x00, flag_z 1; MOVX -> acc 0x02, flag_z 0.
- Nested CALL x4 then RET x4 -> returns to each CALL address+1 in reverse order; fifth nested CALL -> fault 1, pc frozen; RET on empty stack in fresh run -> fault 1.
- HLT at pc 5 -> halted 1, pc 5 held for 10 cycles; resume pulse -> pc 6, halted 0; resume while run=0 ignored.
- PC wrap: NOPs from pc 14 (AW=4) -> 15, 0, 1; CALL at pc 15 pushes 0.
- Reset mid-run after STO R4 with acc 0x55 -> acc, pc, regs, flags all 0 immediately; MOV R4 after reset -> acc 0x00.
